// File: rtl/synth_pkg.sv
// Shared types and defaults for the envelope controller.
package synth_pkg;

  localparam int ENV_W_DEFAULT = 8;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ATTACK  = 3'd1,
    ST_DECAY   = 3'd2,
    ST_SUSTAIN = 3'd3,
    ST_RELEASE = 3'd4
  } env_stage_t;

endpackage

// File: rtl/gate_edge.sv
// Gate edge detector: one-cycle rise/fall strobes from the registered key gate.
// A gate held high through reset is disarmed until it has been seen low.
module gate_edge (
  input  logic clk,
  input  logic rst,
  input  logic gate,
  output logic rise,
  output logic fall
);

  logic r_gate_q;
  logic r_armed;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_gate_q <= 1'b0;
      r_armed  <= ~gate;
    end else begin
      r_gate_q <= gate;
      if (!gate) r_armed <= 1'b1;
    end
  end

  assign rise = gate & ~r_gate_q & r_armed;
  assign fall = ~gate & r_gate_q;

endmodule

// File: rtl/envelope_ctrl.sv
// ADSR envelope generator stepped by step_tick; all outputs registered.
// Define ENV_RETRIGGER_EN to let a new key press restart ATTACK from the current level.
module envelope_ctrl
  import synth_pkg::*;
#(
  parameter int ENV_W = ENV_W_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             gate,
  input  logic             step_tick,
  input  logic [ENV_W-1:0] attack_step,
  input  logic [ENV_W-1:0] decay_step,
  input  logic [ENV_W-1:0] release_step,
  input  logic [ENV_W-1:0] sustain_level,
  output logic [ENV_W-1:0] env,
  output logic [2:0]       stage,
  output logic             busy,
  output logic             done
);

`ifdef ENV_RETRIGGER_EN
  localparam logic RETRIG = 1'b1;
`else
  localparam logic RETRIG = 1'b0;
`endif

  localparam logic [ENV_W-1:0] MAX = '1;

  logic w_rise;
  logic w_fall;

  env_stage_t       r_stage;
  logic [ENV_W-1:0] r_env;
  logic             r_busy;
  logic             r_done;

  gate_edge u_gate_edge (
    .clk  (clk),
    .rst  (rst),
    .gate (gate),
    .rise (w_rise),
    .fall (w_fall)
  );

  // Attack sum is one bit wider so overflow saturates at MAX instead of wrapping.
  logic [ENV_W:0]   w_attack_sum;
  logic [ENV_W-1:0] w_decay_gap;
  logic             w_attack_full;
  logic             w_decay_snap;
  logic             w_release_snap;

  assign w_attack_sum   = {1'b0, r_env} + {1'b0, attack_step};
  assign w_attack_full  = (attack_step == '0) || (w_attack_sum >= {1'b0, MAX});
  assign w_decay_gap    = r_env - sustain_level;
  assign w_decay_snap   = (decay_step == '0) || (r_env <= sustain_level) ||
                          (w_decay_gap <= decay_step);
  assign w_release_snap = (release_step == '0) || (r_env <= release_step);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_stage <= ST_IDLE;
      r_env   <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_stage)
        ST_IDLE: begin
          if (w_rise) begin
            r_stage <= ST_ATTACK;
            r_busy  <= 1'b1;
          end
        end
        ST_ATTACK: begin
          if (w_fall) begin
            r_stage <= ST_RELEASE;
          end else if (step_tick) begin
            if (w_attack_full) begin
              r_env   <= MAX;
              r_stage <= ST_DECAY;
            end else begin
              r_env <= w_attack_sum[ENV_W-1:0];
            end
          end
        end
        ST_DECAY: begin
          if (RETRIG && w_rise) begin
            r_stage <= ST_ATTACK;
          end else if (w_fall) begin
            r_stage <= ST_RELEASE;
          end else if (step_tick) begin
            if (w_decay_snap) begin
              r_env   <= sustain_level;
              r_stage <= ST_SUSTAIN;
            end else begin
              r_env <= r_env - decay_step;
            end
          end
        end
        ST_SUSTAIN: begin
          if (RETRIG && w_rise) begin
            r_stage <= ST_ATTACK;
          end else if (w_fall) begin
            r_stage <= ST_RELEASE;
          end else begin
            r_env <= sustain_level;
          end
        end
        ST_RELEASE: begin
          if (RETRIG && w_rise) begin
            r_stage <= ST_ATTACK;
          end else if (step_tick) begin
            if (w_release_snap) begin
              r_env   <= '0;
              r_stage <= ST_IDLE;
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
            end else begin
              r_env <= r_env - release_step;
            end
          end
        end
        default: begin
          r_stage <= ST_IDLE;
          r_env   <= '0;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign env   = r_env;
  assign stage = r_stage;
  assign busy  = r_busy;
  assign done  = r_done;

endmodule

// File: tb/tb_envelope_ctrl.sv
// Self-checking bench for envelope_ctrl: vector table, hand-written corner sequences,
// and randomized traffic against an integer reference model.
module tb_envelope_ctrl;

  localparam int W    = 8;
  localparam int MAXV = (1 << W) - 1;

`ifdef ENV_RETRIGGER_EN
  localparam bit RETRIG = 1'b1;
`else
  localparam bit RETRIG = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst;
  logic         gate;
  logic         step_tick;
  logic [W-1:0] attack_step;
  logic [W-1:0] decay_step;
  logic [W-1:0] release_step;
  logic [W-1:0] sustain_level;
  logic [W-1:0] env;
  logic [2:0]   stage;
  logic         busy;
  logic         done;

  envelope_ctrl #(.ENV_W(W)) dut (
    .clk           (clk),
    .rst           (rst),
    .gate          (gate),
    .step_tick     (step_tick),
    .attack_step   (attack_step),
    .decay_step    (decay_step),
    .release_step  (release_step),
    .sustain_level (sustain_level),
    .env           (env),
    .stage         (stage),
    .busy          (busy),
    .done          (done)
  );

  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_out(input string tag, input int e_env, input int e_stage, input bit e_done);
    check({tag, " env"},   32'(env),   32'(e_env));
    check({tag, " stage"}, 32'(stage), 32'(e_stage));
    check({tag, " done"},  32'(done),  32'(e_done));
    check({tag, " busy"},  32'(busy),  32'(e_stage != 0));
  endtask

  // Reference model: envelope as a plain integer walking through the ADSR rules.
  int m_stage, m_env;
  bit m_gprev, m_armed, m_done;

  task automatic model_update();
    bit rise, fall;
    int a, d, s, r;
    a = int'(attack_step);
    d = int'(decay_step);
    s = int'(sustain_level);
    r = int'(release_step);
    if (rst) begin
      m_stage = 0; m_env = 0; m_gprev = 0; m_done = 0;
      m_armed = !gate;
      return;
    end
    rise   = gate && !m_gprev && m_armed;
    fall   = !gate && m_gprev;
    m_done = 0;
    case (m_stage)
      0: if (rise) m_stage = 1;
      1: begin
        if (fall) m_stage = 4;
        else if (step_tick) begin
          m_env = (a == 0 || m_env + a > MAXV) ? MAXV : m_env + a;
          if (m_env == MAXV) m_stage = 2;
        end
      end
      2: begin
        if (RETRIG && rise) m_stage = 1;
        else if (fall) m_stage = 4;
        else if (step_tick) begin
          if (d == 0 || m_env - s <= d) begin
            m_env = s; m_stage = 3;
          end else m_env = m_env - d;
        end
      end
      3: begin
        if (RETRIG && rise) m_stage = 1;
        else if (fall) m_stage = 4;
        else m_env = s;
      end
      4: begin
        if (RETRIG && rise) m_stage = 1;
        else if (step_tick) begin
          if (r == 0 || m_env <= r) begin
            m_env = 0; m_stage = 0; m_done = 1;
          end else m_env = m_env - r;
        end
      end
      default: begin m_stage = 0; m_env = 0; end
    endcase
    m_gprev = gate;
    if (!gate) m_armed = 1;
  endtask

  task automatic step();
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic drive(input bit r, input bit g, input bit t);
    rst = r; gate = g; step_tick = t;
  endtask

  task automatic set_steps(input int a, input int d, input int s, input int r);
    attack_step = W'(a); decay_step = W'(d); sustain_level = W'(s); release_step = W'(r);
  endtask

  task automatic do_reset();
    drive(1, 0, 0);
    step();
    check_out("reset", 0, 0, 0);
  endtask

  typedef struct {
    bit rst, gate, tick;
    int e_env, e_stage;
    bit e_done;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(input bit r, input bit g, input bit t,
                              input int e_env, input int e_stage, input bit e_done);
    vec_t v;
    v.rst = r; v.gate = g; v.tick = t;
    v.e_env = e_env; v.e_stage = e_stage; v.e_done = e_done;
    vecs.push_back(v);
  endfunction

  initial begin
    drive(1, 0, 0);
    set_steps(64, 16, 128, 32);

    // Full ADSR pass: attack 64, decay 16 to sustain 128, release 32.
    add(1, 0, 0,   0, 0, 0);
    add(0, 1, 0,   0, 1, 0);
    add(0, 1, 1,  64, 1, 0);
    add(0, 1, 1, 128, 1, 0);
    add(0, 1, 1, 192, 1, 0);
    add(0, 1, 1, 255, 2, 0);
    add(0, 1, 1, 239, 2, 0);
    add(0, 1, 1, 223, 2, 0);
    add(0, 1, 1, 207, 2, 0);
    add(0, 1, 1, 191, 2, 0);
    add(0, 1, 1, 175, 2, 0);
    add(0, 1, 1, 159, 2, 0);
    add(0, 1, 1, 143, 2, 0);
    add(0, 1, 1, 128, 3, 0);
    add(0, 1, 0, 128, 3, 0);
    add(0, 0, 1, 128, 4, 0);
    add(0, 0, 1,  96, 4, 0);
    add(0, 0, 1,  64, 4, 0);
    add(0, 0, 1,  32, 4, 0);
    add(0, 0, 1,   0, 0, 1);
    add(0, 0, 1,   0, 0, 0);

    foreach (vecs[i]) begin
      drive(vecs[i].rst, vecs[i].gate, vecs[i].tick);
      step();
      check_out($sformatf("vec%0d", i), vecs[i].e_env, vecs[i].e_stage, vecs[i].e_done);
    end

    // Zero steps snap to MAX then to sustain; live sustain change follows next cycle.
    set_steps(0, 0, 100, 32);
    do_reset();
    drive(0, 1, 0); step(); check_out("zero press", 0, 1, 0);
    drive(0, 1, 1); step(); check_out("zero atk", 255, 2, 0);
    drive(0, 1, 1); step(); check_out("zero dec", 100, 3, 0);
    sustain_level = 8'd128;
    drive(0, 1, 0); step(); check_out("sus 128", 128, 3, 0);
    sustain_level = 8'd50;
    step(); check_out("sus 50", 50, 3, 0);

    // Gate fall coinciding with a tick in ATTACK: release wins, env held.
    set_steps(64, 16, 128, 32);
    do_reset();
    drive(0, 1, 0); step(); check_out("coin press", 0, 1, 0);
    drive(0, 1, 1); step(); check_out("coin atk", 64, 1, 0);
    drive(0, 0, 1); step(); check_out("coin fall", 64, 4, 0);

    // Re-press during RELEASE at env 96.
    set_steps(0, 0, 128, 32);
    do_reset();
    drive(0, 1, 0); step();
    drive(0, 1, 1); step(); step(); check_out("rt sus", 128, 3, 0);
    drive(0, 0, 0); step(); check_out("rt rel", 128, 4, 0);
    drive(0, 0, 1); step(); check_out("rt 96", 96, 4, 0);
    attack_step = 8'd64;
    drive(0, 1, 1); step();
    if (RETRIG) begin
      check_out("rt press", 96, 1, 0);
      step(); check_out("rt 160", 160, 1, 0);
    end else begin
      check_out("rt ign", 64, 4, 0);
      step(); check_out("rt 32", 32, 4, 0);
      step(); check_out("rt end", 0, 0, 1);
      step(); check_out("rt idle", 0, 0, 0);
    end

    // Reset mid-DECAY at env 200 with gate held through reset release.
    set_steps(0, 55, 0, 32);
    do_reset();
    drive(0, 1, 0); step();
    drive(0, 1, 1); step(); check_out("rd max", 255, 2, 0);
    step(); check_out("rd 200", 200, 2, 0);
    drive(1, 1, 1); step(); check_out("rd abort", 0, 0, 0);
    drive(0, 1, 1);
    for (int i = 0; i < 4; i++) begin
      step(); check_out("rd held", 0, 0, 0);
    end
    drive(0, 0, 0); step(); check_out("rd low", 0, 0, 0);
    drive(0, 1, 0); step(); check_out("rd repress", 0, 1, 0);

    // Randomized traffic against the reference model.
    set_steps(32, 16, 128, 32);
    do_reset();
    for (int c = 0; c < 4000; c++) begin
      if (c % 60 == 0) begin
        attack_step  = ($urandom_range(0, 7) == 0) ? '0 : W'($urandom_range(1, 255));
        decay_step   = ($urandom_range(0, 7) == 0) ? '0 : W'($urandom_range(1, 255));
        release_step = ($urandom_range(0, 7) == 0) ? '0 : W'($urandom_range(1, 255));
      end
      if ($urandom_range(0, 40) == 0) sustain_level = W'($urandom_range(0, 255));
      if ($urandom_range(0, 12) == 0) gate = ~gate;
      step_tick = 1'($urandom_range(0, 1));
      rst       = ($urandom_range(0, 499) == 0);
      step();
      check("rnd env",   32'(env),   32'(m_env));
      check("rnd stage", 32'(stage), 32'(m_stage));
      check("rnd done",  32'(done),  32'(m_done));
      check("rnd busy",  32'(busy),  32'(m_stage != 0));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
